// File: rtl/cc_row_shifter.sv
// Loadable row shifter feeding the register/clear stage; rotate instead of zero-fill when CC_ROW_SHIFTER_WRAP_EN is defined.
// Latency: a shift lands PRESCALE_MAX+1 clocks after load (or after the previous step), and step pulses with the new data.
// Backpressure: none; the block free-runs and downstream must take each step when it is presented.
module cc_row_shifter #(
    parameter int WIDTH          = 4,
    parameter int PRESCALE_WIDTH = 4,
    parameter int PRESCALE_MAX   = 9
) (
    input  logic             CC_ROW_SHIFTER_CLOCK_50,
    input  logic             CC_ROW_SHIFTER_RESET_InHigh,
    input  logic             CC_ROW_SHIFTER_clear_InLow,
    input  logic             CC_ROW_SHIFTER_load_InLow,
    input  logic [WIDTH-1:0] CC_ROW_SHIFTER_data_InBUS,
    input  logic [1:0]       CC_ROW_SHIFTER_shiftselection_In,
    output logic [WIDTH-1:0] CC_ROW_SHIFTER_data_OutBUS,
    output logic             CC_ROW_SHIFTER_step_OutHigh,
    output logic             CC_ROW_SHIFTER_edgeLeft_OutHigh,
    output logic             CC_ROW_SHIFTER_edgeRight_OutHigh
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [PRESCALE_WIDTH-1:0] CNT_MAX = PRESCALE_WIDTH'(PRESCALE_MAX);

    logic [0:0]                state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]          data_q, data_d;
    logic                      step_q, step_d;
    logic [WIDTH-1:0]          shl_dat, shr_dat;
    logic                      tick;

    always_comb begin
`ifdef CC_ROW_SHIFTER_WRAP_EN
        shl_dat = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        shr_dat = {data_q[0], data_q[WIDTH-1:1]};
`else
        shl_dat = {data_q[WIDTH-2:0], 1'b0};
        shr_dat = {1'b0, data_q[WIDTH-1:1]};
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        step_d  = 1'b0;
        tick    = (state_q == ST_RUN) && (cnt_q == CNT_MAX);
        if (!CC_ROW_SHIFTER_clear_InLow) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            data_d  = '0;
        end else if (!CC_ROW_SHIFTER_load_InLow) begin
            // A load always restarts the step period, even on a terminal count.
            state_d = ST_RUN;
            cnt_d   = '0;
            data_d  = CC_ROW_SHIFTER_data_InBUS;
        end else if (state_q == ST_RUN) begin
            cnt_d = tick ? '0 : cnt_q + PRESCALE_WIDTH'(1);
            if (tick) begin
                case (CC_ROW_SHIFTER_shiftselection_In)
                    2'b01: begin
                        data_d = shl_dat;
                        step_d = 1'b1;
                    end
                    2'b10: begin
                        data_d = shr_dat;
                        step_d = 1'b1;
                    end
                    default: data_d = data_q;
                endcase
            end
        end
    end

    always_ff @(posedge CC_ROW_SHIFTER_CLOCK_50 or posedge CC_ROW_SHIFTER_RESET_InHigh) begin
        if (CC_ROW_SHIFTER_RESET_InHigh) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            step_q  <= step_d;
        end
    end

    assign CC_ROW_SHIFTER_data_OutBUS       = data_q;
    assign CC_ROW_SHIFTER_step_OutHigh      = step_q;
    assign CC_ROW_SHIFTER_edgeLeft_OutHigh  = data_q[WIDTH-1];
    assign CC_ROW_SHIFTER_edgeRight_OutHigh = data_q[0];

endmodule

// File: doc/cc_row_shifter.md
Name: cc_row_shifter

Overview:
- Timed, loadable row shifter directly upstream of the game's combinational register/clear stage (CC_REG-style stage, same WIDTH).
- Produces one row pattern of the road/obstacle field and moves it left or right at a prescaled game rate.
- Its output bus feeds the downstream stage's data input; its step pulse tells later stages a new row value is present.

Parameters:
- WIDTH, 4, row width in bits; must equal downstream register width.
- PRESCALE_WIDTH, 4, width of internal step counter.
- PRESCALE_MAX, 9, a step fires every PRESCALE_MAX+1 clocks while running; range 0..2^PRESCALE_WIDTH-1.

Ports:
- CC_ROW_SHIFTER_CLOCK_50  input  1  system clock, all state on rising edge.
- CC_ROW_SHIFTER_RESET_InHigh  input  1  asynchronous, active-high reset.
- CC_ROW_SHIFTER_clear_InLow  input  1  synchronous clear, active low.
- CC_ROW_SHIFTER_load_InLow  input  1  synchronous parallel load, active low.
- CC_ROW_SHIFTER_data_InBUS  input  WIDTH  pattern captured on load.
- CC_ROW_SHIFTER_shiftselection_In  input  2  00 hold, 01 shift left, 10 shift right, 11 hold.
- CC_ROW_SHIFTER_data_OutBUS  output  WIDTH  current row pattern.
- CC_ROW_SHIFTER_step_OutHigh  output  1  one-cycle pulse, registered, when a shift was applied.
- CC_ROW_SHIFTER_edgeLeft_OutHigh  output  1  current MSB set.
- CC_ROW_SHIFTER_edgeRight_OutHigh  output  1  current LSB set.

Behaviour:
- Reset (async assert, sync release): data_OutBUS=0, step=0, prescaler=0, FSM=IDLE; edge flags therefore 0.
- FSM states: IDLE (no pattern loaded, prescaler held at 0), RUN (prescaler counting).
- IDLE -> RUN on load. RUN -> IDLE on clear. Load while in RUN reloads data and stays in RUN.
- Priority per edge: reset > clear > load > shift step. Clear and load in same cycle: clear wins.
- Clear: data=0, prescaler=0, step=0, FSM=IDLE.
- Load: data=data_InBUS, prescaler=0, step=0; no shift that cycle even if counter was at terminal.
- RUN: prescaler increments each clock; at PRESCALE_MAX it wraps to 0 and a step event occurs.
- Step event with selection 01: data = {data[WIDTH-2:0],1'b0}; 10: data = {1'b0,data[WIDTH-1:1]}; 00/11: data unchanged and step output stays 0 (counter still wraps).
- step_OutHigh is high for exactly the cycle after the edge on which the shift was registered, aligned with the new data value.
- PRESCALE_MAX=0: step event every clock in RUN.
- Selection changes are sampled only at the step event; changes between events have no effect.
- Pattern shifting to all-zero stays in RUN; further steps keep 0 and still pulse step on 01/10.
- Edge flags are combinational from the data register: edgeLeft=data[WIDTH-1], edgeRight=data[0].
- Reset asserted mid-count: immediate return to reset values, no step pulse emitted.

Optional Feature:
- Macro CC_ROW_SHIFTER_WRAP_EN.
- Defined: shifts rotate (left: {data[WIDTH-2:0],data[WIDTH-1]}; right: {data[0],data[WIDTH-1:1]}), pattern never lost.
- Undefined: zero-fill as in Behaviour. All other behaviour identical.

Test Plan:
- Reset during RUN with data=4'b1010 -> outputs 0, step 0, next load required before any shift.
- Load 4'b0011, selection 01, PRESCALE_MAX=9 -> data 4'b0110 with step pulse 10 clocks after load edge, then 4'b1100 (edgeLeft=1) 10 clocks later, then 4'b1000, then 4'b0000.
- Load 4'b1000, selection 10 -> 4'b0100, 4'b0010, 4'b0001 (edgeRight=1), 4'b0000 at 10-clock intervals; with CC_ROW_SHIFTER_WRAP_EN, 4'b0001 -> 4'b1000.
- Selection 00 in RUN for 30 clocks after load 4'b0101 -> data stays 4'b0101, step never asserted.
- Load and clear asserted same cycle with data_InBUS=4'b1111 -> data 0, FSM IDLE, no steps for 40 clocks.
- Reload 4'b1001 one clock before a terminal count -> data 4'b1001, prescaler restarts, first shift 10 clocks later.
